mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter MUL_LAT, default 4, multiply busy cycles; SHALL be 1..8.
REQ-002 Port clk, input, 1, single rising-edge clock for all state.
REQ-003 Port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 Port start, input, 1, op valid this cycle.
REQ-005 Port op, input, 3, MULT/MULTU/DIV/DIVU/MTHI/MTLO encoding.
REQ-006 Port num1, input, 32, rs operand / dividend / move source.
REQ-007 Port num2, input, 32, rt operand / divisor.
REQ-008 Port flush, input, 1, abort in-flight op.
REQ-009 Port busy, output, 1, op in flight; upstream stalls MFHI/MFLO and new ops.
REQ-010 Port hi, output, 32, HI register.
REQ-011 Port lo, output, 32, LO register.

Function
REQ-012 States SHALL be IDLE, MUL, DIV; busy=1 exactly when state!=IDLE.
REQ-013 start in IDLE with op MULT/MULTU SHALL latch operands, enter MUL, and load the counter with MUL_LAT.
REQ-014 start in IDLE with op DIV/DIVU SHALL latch operands, enter DIV, and load the counter with 32.
REQ-015 Counter SHALL decrement each busy cycle; on the edge where it reaches 0, hi/lo SHALL be written and state SHALL return to IDLE.
REQ-016 Timing: start at cycle T gives busy=1 for T+1..T+N and new hi/lo with busy=0 at T+N+1 (N=MUL_LAT or 32).
REQ-017 MULT: {hi,lo} SHALL be the signed 64-bit product; MULTU: the unsigned 64-bit product.
REQ-018 DIV: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
REQ-019 DIVU: lo/hi = unsigned quotient/remainder.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 Divide by zero (either signedness) SHALL give lo=0xFFFFFFFF, hi=num1, with normal 32-cycle latency.
REQ-022 Division SHALL be restoring, one quotient bit per cycle, on magnitudes; sign fix applied at the final write.
REQ-023 MTHI/MTLO with start in IDLE SHALL write hi/lo from num1 on the next edge; busy stays 0.
REQ-024 start while busy SHALL be ignored; in-flight op unaffected.
REQ-025 flush SHALL force IDLE on the next edge and leave hi/lo unchanged; flush has priority over start and over a completing write in the same cycle.
REQ-026 Invalid op codes with start SHALL be ignored.
REQ-027 hi/lo SHALL hold value except on the writes defined above.

Reset
REQ-028 rst_n=0 at an edge SHALL set state=IDLE, counter=0, busy=0, hi=0, lo=0, and clear latched operands, including mid-operation.
REQ-029 Reset SHALL take priority over flush and start.

Structure
REQ-030 Op encodings (MDU_MULT..MDU_MTLO) and the 32-cycle divide constant SHALL live in the shared definitions package alongside the ALU command codes.
REQ-031 The iterative divider datapath SHALL be the sub-module div_iter; control FSM and multiplier stay in mul_div_unit.

Verification
REQ-032 MULT 0xFFFFFFFE x 0x00000003 -> after 4 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 DIV -7 / 2 -> busy 32 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 MTHI 0x12345678, then start MULT while busy from a prior DIV -> hi=0x12345678 until the DIV completes, second op ignored.
REQ-036 flush at busy cycle 10 of DIV -> busy=0 next cycle, hi/lo keep pre-DIV values.
REQ-037 rst_n=0 at busy cycle 2 of MULT -> busy=0, hi=lo=0 next cycle; a subsequent MTLO 7 -> lo=7.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op codes, ALU commands and MDU constants
package mul_div_unit_pkg;

    // Multiply/divide unit op codes; 6 and 7 are unused and ignored.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    // ALU command codes shared with the integer pipe.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // One quotient bit per cycle for a 32-bit divide.
    localparam int unsigned DIV_CYCLES = 32;

    // Two's-complement magnitude when neg is set, pass-through otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// rtl/mul_div_unit_div_iter.sv - restoring divider datapath, one quotient bit per step
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load              capture dividend/divisor magnitudes, clear remainder
//   step              perform one restoring iteration
//   dividend, divisor unsigned magnitudes captured on load
//   quo_next, rem_next quotient/remainder after the current step (combinational),
//                      so the caller can write results on the final step's edge
module div_iter
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] shifted;
    logic [32:0] diff;

    // The quotient register starts as the dividend and shifts its bits out
    // into the remainder while quotient bits shift in from the bottom.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dvs_q};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo_q[30:0], 1'b1};
        end else begin
            rem_next = shifted[31:0];
            quo_next = {quo_q[30:0], 1'b0};
        end

        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = 32'd0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = rem_next;
            quo_d = quo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - HI/LO multiply/divide unit with fixed-latency multiply and iterative divide
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start, op   op request (mdu_op_e) accepted only when idle
//   num1, num2  rs/dividend/move source, rt/divisor
//   flush       abort in-flight op on the next edge, hi/lo untouched
//   busy        op in flight
//   hi, lo      architectural HI/LO registers
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        div_load;
    logic        div_step;
    logic        in_signed;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [63:0] prod;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    assign in_signed = (op == MDU_DIV);

    div_iter u_div_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag32(num1, in_signed && num1[31])),
        .divisor  (mag32(num2, in_signed && num2[31])),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // Product from latched operands; sign-extending to 64 bits makes the
    // low 64 bits of the product the signed result.
    always_comb begin
        if (sgn_q) begin
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end else begin
            prod = {32'd0, a_q} * {32'd0, b_q};
        end
    end

    // Sign fix on the final write: quotient negative when operand signs
    // differ, remainder follows the dividend. Divide by zero bypasses the
    // datapath result entirely.
    always_comb begin
        div_lo = mag32(quo_next, sgn_q && (a_q[31] ^ b_q[31]));
        div_hi = mag32(rem_next, sgn_q && a_q[31]);
        if (b_q == 32'd0) begin
            div_lo = 32'hFFFF_FFFF;
            div_hi = a_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_load = 1'b0;
        div_step = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                a_d     = num1;
                                b_d     = num2;
                                sgn_d   = (op == MDU_MULT);
                                cnt_d   = 6'(MUL_LAT);
                                state_d = ST_MUL;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                a_d      = num1;
                                b_d      = num2;
                                sgn_d    = in_signed;
                                cnt_d    = 6'(DIV_CYCLES);
                                div_load = 1'b1;
                                state_d  = ST_DIV;
                            end
                            MDU_MTHI: hi_d = num1;
                            MDU_MTLO: lo_d = num1;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                        state_d = ST_IDLE;
                    end
                end
                ST_DIV: begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_d    = div_hi;
                        lo_d    = div_lo;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
